// File: rtl/memory_interface_controller.sv
// Word-addressed ROM/RAM front end with programmable wait states, MFC/ERROR handshake.
// Optional macro MEMCTL_ROM_WRITE_PROTECT_EN makes writes into the ROM range fault.
module memory_interface_controller #(
    parameter int          ROM_WORDS  = 128,
    parameter logic [31:0] RAM_BASE   = 32'h100,
    parameter int          RAM_WORDS  = 256,
    parameter int          READ_WAIT  = 2,
    parameter int          WRITE_WAIT = 1
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic [31:0] MEM_Address,
    input  logic [31:0] MEM_Data_In,
    input  logic [1:0]  MEM_r_w_z_z,
    output logic [31:0] MEM_Data_Out,
    output logic        MEM_MFC,
    output logic        MEM_ERROR,
    output logic [31:0] ROM_Address,
    input  logic [31:0] ROM_Data,
    output logic [31:0] RAM_Address,
    output logic [31:0] RAM_Data_Wr,
    output logic        RAM_Write,
    input  logic [31:0] RAM_Data_Rd,
    output logic [2:0]  Ctl_State
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_ACCESS = 3'd2,
        S_DONE   = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    localparam int          RAM_AW     = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam logic [31:0] ROM_LIMIT  = 32'(ROM_WORDS);
    localparam logic [31:0] RAM_SIZE   = 32'(RAM_WORDS);
    localparam logic [3:0]  RD_WAIT    = 4'(READ_WAIT);
    localparam logic [3:0]  WR_WAIT    = 4'(WRITE_WAIT);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [1:0]  op_q, op_d;
    logic        rom_sel_q, rom_sel_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mfc_q, mfc_d;
    logic        err_q, err_d;
    logic [31:0] rom_addr_q, rom_addr_d;
    logic [31:0] ram_addr_q, ram_addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        ram_we_q, ram_we_d;

    logic [31:0] ram_off;
    logic        hit_rom, hit_ram, live_write, live_fault, req_changed;
    logic [3:0]  wait_cnt;

    assign ram_off    = MEM_Address - RAM_BASE;
    assign hit_rom    = (MEM_Address < ROM_LIMIT);
    assign hit_ram    = (MEM_Address >= RAM_BASE) && (ram_off < RAM_SIZE);
    assign live_write = MEM_r_w_z_z[0];
    assign wait_cnt   = live_write ? WR_WAIT : RD_WAIT;

`ifdef MEMCTL_ROM_WRITE_PROTECT_EN
    assign live_fault = !(hit_rom || hit_ram) || (hit_rom && live_write);
`else
    assign live_fault = !(hit_rom || hit_ram);
`endif

    // Write data only matters for identity when the captured op is a write.
    assign req_changed = MEM_r_w_z_z[1] || (MEM_r_w_z_z != op_q) || (MEM_Address != addr_q)
                         || (op_q[0] && (MEM_Data_In != data_q));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        op_d       = op_q;
        rom_sel_d  = rom_sel_q;
        rdata_d    = rdata_q;
        rom_addr_d = rom_addr_q;
        ram_addr_d = ram_addr_q;
        wdata_d    = wdata_q;
        ram_we_d   = 1'b0;
        // Completion flags lag the state by one edge so MFC follows DONE/FAULT entry.
        mfc_d      = (state_q == S_DONE) || (state_q == S_FAULT);
        err_d      = (state_q == S_FAULT);

        case (state_q)
            S_IDLE: begin
                if (!MEM_r_w_z_z[1]) begin
                    addr_d    = MEM_Address;
                    data_d    = MEM_Data_In;
                    op_d      = MEM_r_w_z_z;
                    rom_sel_d = hit_rom;
                    if (live_fault) begin
                        state_d = S_FAULT;
                        rdata_d = 32'd0;
                    end else begin
                        if (hit_rom) begin
                            rom_addr_d = MEM_Address;
                        end else begin
                            ram_addr_d = {{(32-RAM_AW){1'b0}}, ram_off[RAM_AW-1:0]};
                        end
                        if (live_write) begin
                            wdata_d = MEM_Data_In;
                        end
                        if (wait_cnt == 4'd0) begin
                            state_d  = S_ACCESS;
                            ram_we_d = live_write && hit_ram;
                        end else begin
                            cnt_d   = wait_cnt - 4'd1;
                            state_d = S_WAIT;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (req_changed) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d  = S_ACCESS;
                    ram_we_d = op_q[0] && !rom_sel_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACCESS: begin
                if (!op_q[0]) begin
                    rdata_d = rom_sel_q ? ROM_Data : RAM_Data_Rd;
                end
                state_d = req_changed ? S_IDLE : S_DONE;
            end
            S_DONE, S_FAULT: begin
                if (req_changed) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= 32'd0;
            data_q     <= 32'd0;
            op_q       <= 2'b10;
            rom_sel_q  <= 1'b0;
            rdata_q    <= 32'd0;
            mfc_q      <= 1'b0;
            err_q      <= 1'b0;
            rom_addr_q <= 32'd0;
            ram_addr_q <= 32'd0;
            wdata_q    <= 32'd0;
            ram_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            op_q       <= op_d;
            rom_sel_q  <= rom_sel_d;
            rdata_q    <= rdata_d;
            mfc_q      <= mfc_d;
            err_q      <= err_d;
            rom_addr_q <= rom_addr_d;
            ram_addr_q <= ram_addr_d;
            wdata_q    <= wdata_d;
            ram_we_q   <= ram_we_d;
        end
    end

    assign MEM_Data_Out = rdata_q;
    assign MEM_MFC      = mfc_q;
    assign MEM_ERROR    = err_q;
    assign ROM_Address  = rom_addr_q;
    assign RAM_Address  = ram_addr_q;
    assign RAM_Data_Wr  = wdata_q;
    assign RAM_Write    = ram_we_q;
    assign Ctl_State    = state_q;

endmodule

// File: tb/tb_memory_interface_controller.sv
// Scoreboard bench: stimulus queues expected MFC responses, a monitor checks each MFC rise.
module tb_memory_interface_controller;

    logic        clk;
    logic        rst_n;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [1:0]  mem_rw;
    logic [31:0] MEM_Data_Out;
    logic        MEM_MFC;
    logic        MEM_ERROR;
    logic [31:0] ROM_Address;
    logic [31:0] ROM_Data;
    logic [31:0] RAM_Address;
    logic [31:0] RAM_Data_Wr;
    logic        RAM_Write;
    logic [31:0] RAM_Data_Rd;
    logic [2:0]  Ctl_State;

    memory_interface_controller dut (
        .Clock        (clk),
        .Reset_n      (rst_n),
        .MEM_Address  (mem_addr),
        .MEM_Data_In  (mem_din),
        .MEM_r_w_z_z  (mem_rw),
        .MEM_Data_Out (MEM_Data_Out),
        .MEM_MFC      (MEM_MFC),
        .MEM_ERROR    (MEM_ERROR),
        .ROM_Address  (ROM_Address),
        .ROM_Data     (ROM_Data),
        .RAM_Address  (RAM_Address),
        .RAM_Data_Wr  (RAM_Data_Wr),
        .RAM_Write    (RAM_Write),
        .RAM_Data_Rd  (RAM_Data_Rd),
        .Ctl_State    (Ctl_State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory models with one-cycle read latency.
    logic [31:0] rom_mem [0:127];
    logic [31:0] ram_mem [0:255];
    initial begin
        for (int i = 0; i < 128; i++) rom_mem[i] = 32'hF000_0000 | i;
        for (int i = 0; i < 256; i++) ram_mem[i] = 32'hD000_0000 | i;
        rom_mem[5] = 32'h1234_5678;
        ram_mem[1] = 32'hA5A5_0101;
    end
    always @(posedge clk) begin
        ROM_Data    <= rom_mem[ROM_Address[6:0]];
        RAM_Data_Rd <= ram_mem[RAM_Address[7:0]];
        if (RAM_Write) ram_mem[RAM_Address[7:0]] <= RAM_Data_Wr;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] cyc;
        logic        err;
        logic [31:0] data;
    } exp_t;
    exp_t sb_q[$];

    int passed = 0;
    int total  = 0;
    int rise_cnt = 0;
    int we_cnt = 0;
    logic [31:0] we_addr = 32'd0;
    logic [31:0] we_data = 32'd0;
    logic mfc_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every MFC rise is matched against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (RAM_Write) begin
                we_cnt++;
                we_addr = RAM_Address;
                we_data = RAM_Data_Wr;
            end
            if (MEM_MFC && !mfc_prev) begin
                if (sb_q.size() == 0) begin
                    check("sb_nonempty_at_mfc", 32'(sb_q.size()), 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    check("mfc_cycle", 32'(cyc), e.cyc);
                    check("mfc_error", {31'd0, MEM_ERROR}, {31'd0, e.err});
                    check("mfc_data", MEM_Data_Out, e.data);
                    $display("txn: mfc at cycle %0d err=%0b data=%h", cyc, MEM_ERROR, MEM_Data_Out);
                end
                rise_cnt++;
            end
            mfc_prev = MEM_MFC;
        end
    end

    task automatic wait_rise(input string name, input int start);
        for (int i = 0; i < 30 && rise_cnt == start; i++) @(negedge clk);
        check({name, "_done"}, 32'(rise_cnt - start), 32'd1);
    endtask

    task automatic do_req(input string name, input logic [1:0] op, input logic [31:0] addr,
                          input logic [31:0] d, input int lat, input logic e_err,
                          input logic [31:0] e_data);
        int start;
        @(negedge clk);
        mem_rw   = op;
        mem_addr = addr;
        mem_din  = d;
        sb_q.push_back({32'(cyc + 1 + lat), e_err, e_data});
        start = rise_cnt;
        wait_rise(name, start);
        repeat (2) @(negedge clk);
        check({name, "_hold_mfc"}, {31'd0, MEM_MFC}, 32'd1);
        check({name, "_hold_data"}, MEM_Data_Out, e_data);
        mem_rw = 2'b10;
        repeat (2) @(negedge clk);
        check({name, "_mfc_drop"}, {31'd0, MEM_MFC}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data_out"}, MEM_Data_Out, 32'd0);
        check({tag, "_mfc"}, {31'd0, MEM_MFC}, 32'd0);
        check({tag, "_error"}, {31'd0, MEM_ERROR}, 32'd0);
        check({tag, "_ram_write"}, {31'd0, RAM_Write}, 32'd0);
        check({tag, "_rom_addr"}, ROM_Address, 32'd0);
        check({tag, "_ram_addr"}, RAM_Address, 32'd0);
        check({tag, "_ram_wdata"}, RAM_Data_Wr, 32'd0);
        check({tag, "_state"}, 32'(Ctl_State), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, start, we0;
        rst_n    = 1'b0;
        mem_rw   = 2'b10;
        mem_addr = 32'd0;
        mem_din  = 32'd0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // ROM read, READ_WAIT=2: MFC four cycles after sample
        do_req("rom_read5", 2'b00, 32'd5, 32'd0, 4, 1'b0, 32'h1234_5678);

        // RAM write, WRITE_WAIT=1: Data_Out keeps the last read value
        we0 = we_cnt;
        do_req("ram_write104", 2'b01, 32'h104, 32'hCAFE_F00D, 3, 1'b0, 32'h1234_5678);
        check("write_pulses", 32'(we_cnt - we0), 32'd1);
        check("write_ram_addr", we_addr, 32'd4);
        check("write_ram_data", we_data, 32'hCAFE_F00D);

        do_req("ram_read104", 2'b00, 32'h104, 32'd0, 4, 1'b0, 32'hCAFE_F00D);

        do_req("unmapped8000", 2'b00, 32'h8000, 32'd0, 1, 1'b1, 32'd0);

        we0 = we_cnt;
`ifdef MEMCTL_ROM_WRITE_PROTECT_EN
        do_req("rom_write3", 2'b01, 32'd3, 32'h5555_AAAA, 1, 1'b1, 32'd0);
`else
        do_req("rom_write3", 2'b01, 32'd3, 32'h5555_AAAA, 3, 1'b0, 32'd0);
`endif
        check("rom_write_no_strobe", 32'(we_cnt - we0), 32'd0);

        // Address change during WAIT aborts; the new read samples two edges later
        we0 = we_cnt;
        @(negedge clk);
        mem_rw   = 2'b00;
        mem_addr = 32'h100;
        c0 = cyc;
        start = rise_cnt;
        @(negedge clk);
        check("abort_in_wait_state", 32'(Ctl_State), 32'd1);
        mem_addr = 32'h101;
        sb_q.push_back({32'(c0 + 7), 1'b0, 32'hA5A5_0101});
        wait_rise("abort_reread", start);
        mem_rw = 2'b10;
        repeat (2) @(negedge clk);
        check("abort_no_write", 32'(we_cnt - we0), 32'd0);
        check("abort_mfc_drop", {31'd0, MEM_MFC}, 32'd0);

        // Asynchronous reset while a read is in ACCESS
        @(negedge clk);
        mem_rw   = 2'b00;
        mem_addr = 32'd7;
        repeat (3) @(negedge clk);
        check("pre_reset_access", 32'(Ctl_State), 32'd2);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        mem_rw = 2'b10;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_req("post_reset_read7", 2'b00, 32'd7, 32'd0, 4, 1'b0, 32'hF000_0007);

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
